// File: rtl/demux1to3_buf_pkg.sv
// rtl/demux1to3_buf_pkg.sv - shared select encodings and default width for the 1-to-3 result demux
package demux1to3_buf_pkg;

   localparam int DEFAULT_WIDTH = 16;

   localparam logic [1:0] SEL_A    = 2'b00;
   localparam logic [1:0] SEL_B    = 2'b01;
   localparam logic [1:0] SEL_C    = 2'b10;
   localparam logic [1:0] SEL_DROP = 2'b11;

endpackage

// File: rtl/demux_slot.sv
// rtl/demux_slot.sv - one-entry holding register with valid/ready handshake
module demux_slot
   import demux1to3_buf_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             can_accept
);

   // Slot is free when empty or when its current word leaves this cycle.
   assign can_accept = !out_valid || out_ready;

   // Load wins over drain so a simultaneous load/drain keeps valid high at full rate.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_data  <= load_data;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/demux1to3_buf.sv
// rtl/demux1to3_buf.sv - routes one word stream to three buffered channels, dropping reserved selects
module demux1to3_buf
   import demux1to3_buf_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       in_sel,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] a_data,
   output logic             a_valid,
   input  logic             a_ready,
   output logic [WIDTH-1:0] b_data,
   output logic             b_valid,
   input  logic             b_ready,
   output logic [WIDTH-1:0] c_data,
   output logic             c_valid,
   input  logic             c_ready,
   output logic [CNT_W-1:0] drop_count
);

   logic a_accept;
   logic b_accept;
   logic c_accept;
   logic in_xfer;

   // Ready follows only the selected slot; the drop path always accepts.
   always_comb begin
      in_ready = 1'b1;
      case (in_sel)
         SEL_A:   in_ready = a_accept;
         SEL_B:   in_ready = b_accept;
         SEL_C:   in_ready = c_accept;
         default: in_ready = 1'b1;
      endcase
   end

   assign in_xfer = in_valid && in_ready;

   demux_slot #(.WIDTH(WIDTH)) u_slot_a (
      .clk        (clk),
      .rst        (rst),
      .load       (in_xfer && (in_sel == SEL_A)),
      .load_data  (in_data),
      .out_ready  (a_ready),
      .out_valid  (a_valid),
      .out_data   (a_data),
      .can_accept (a_accept)
   );

   demux_slot #(.WIDTH(WIDTH)) u_slot_b (
      .clk        (clk),
      .rst        (rst),
      .load       (in_xfer && (in_sel == SEL_B)),
      .load_data  (in_data),
      .out_ready  (b_ready),
      .out_valid  (b_valid),
      .out_data   (b_data),
      .can_accept (b_accept)
   );

   demux_slot #(.WIDTH(WIDTH)) u_slot_c (
      .clk        (clk),
      .rst        (rst),
      .load       (in_xfer && (in_sel == SEL_C)),
      .load_data  (in_data),
      .out_ready  (c_ready),
      .out_valid  (c_valid),
      .out_data   (c_data),
      .can_accept (c_accept)
   );

   // Count discarded reserved-select words, sticking at all-ones instead of wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         drop_count <= '0;
      end else if (in_xfer && (in_sel == SEL_DROP) && (drop_count != {CNT_W{1'b1}})) begin
         drop_count <= drop_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_demux1to3_buf.sv
// tb/tb_demux1to3_buf.sv - directed self-checking bench for demux1to3_buf
module tb_demux1to3_buf;

   logic        clk;
   logic        rst;
   logic [15:0] in_data;
   logic [1:0]  in_sel;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a_data;
   logic        a_valid;
   logic        a_ready;
   logic [15:0] b_data;
   logic        b_valid;
   logic        b_ready;
   logic [15:0] c_data;
   logic        c_valid;
   logic        c_ready;
   logic [7:0]  drop_count;

   int n_assert = 0;
   int n_fail   = 0;

   demux1to3_buf #(.WIDTH(16), .CNT_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_data    (in_data),
      .in_sel     (in_sel),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .a_data     (a_data),
      .a_valid    (a_valid),
      .a_ready    (a_ready),
      .b_data     (b_data),
      .b_valid    (b_valid),
      .b_ready    (b_ready),
      .c_data     (c_data),
      .c_valid    (c_valid),
      .c_ready    (c_ready),
      .drop_count (drop_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst      = 1'b1;
      in_data  = 16'h0000;
      in_sel   = 2'b00;
      in_valid = 1'b0;
      a_ready  = 1'b1;
      b_ready  = 1'b1;
      c_ready  = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();

      // reset / idle state
      chk("rst_a_valid", {31'd0, a_valid}, 32'd0);
      chk("rst_b_valid", {31'd0, b_valid}, 32'd0);
      chk("rst_c_valid", {31'd0, c_valid}, 32'd0);
      chk("rst_a_data", {16'd0, a_data}, 32'h0000);
      chk("rst_b_data", {16'd0, b_data}, 32'h0000);
      chk("rst_c_data", {16'd0, c_data}, 32'h0000);
      chk("rst_drop", {24'd0, drop_count}, 32'd0);
      for (int s = 0; s < 4; s++) begin
         in_sel = 2'(s);
         #1;
         chk($sformatf("idle_in_ready_sel%0d", s), {31'd0, in_ready}, 32'd1);
      end

      // one word to each channel, back to back
      in_valid = 1'b1; in_sel = 2'b00; in_data = 16'h1234;
      #1 chk("t2_in_ready_a", {31'd0, in_ready}, 32'd1);
      tick();
      chk("t2_a_valid", {31'd0, a_valid}, 32'd1);
      chk("t2_a_data", {16'd0, a_data}, 32'h1234);
      chk("t2_b_valid0", {31'd0, b_valid}, 32'd0);
      in_sel = 2'b01; in_data = 16'h0F7A;
      tick();
      chk("t2_a_drained", {31'd0, a_valid}, 32'd0);
      chk("t2_b_valid", {31'd0, b_valid}, 32'd1);
      chk("t2_b_data", {16'd0, b_data}, 32'h0F7A);
      in_sel = 2'b10; in_data = 16'h7011;
      tick();
      chk("t2_b_drained", {31'd0, b_valid}, 32'd0);
      chk("t2_c_valid", {31'd0, c_valid}, 32'd1);
      chk("t2_c_data", {16'd0, c_data}, 32'h7011);
      chk("t2_a_data_hold", {16'd0, a_data}, 32'h1234);
      in_valid = 1'b0;
      tick();
      chk("t2_c_drained", {31'd0, c_valid}, 32'd0);

      // stall on A, then bypass to B while A is stuck
      a_ready = 1'b0;
      in_valid = 1'b1; in_sel = 2'b00; in_data = 16'h1234;
      tick();
      chk("t3_a_valid", {31'd0, a_valid}, 32'd1);
      in_data = 16'hABCD;
      #1 chk("t3_in_ready_stall", {31'd0, in_ready}, 32'd0);
      tick();
      chk("t3_a_data_stable", {16'd0, a_data}, 32'h1234);
      chk("t3_a_valid_stall", {31'd0, a_valid}, 32'd1);
      in_sel = 2'b01; in_data = 16'h0F7A;
      #1 chk("t4_in_ready_b", {31'd0, in_ready}, 32'd1);
      tick();
      chk("t4_b_valid", {31'd0, b_valid}, 32'd1);
      chk("t4_b_data", {16'd0, b_data}, 32'h0F7A);
      chk("t4_a_data", {16'd0, a_data}, 32'h1234);
      chk("t4_a_valid", {31'd0, a_valid}, 32'd1);
      in_sel = 2'b00; in_data = 16'hABCD;
      #1 chk("t3_in_ready_still0", {31'd0, in_ready}, 32'd0);
      a_ready = 1'b1;
      #1 chk("t3_in_ready_release", {31'd0, in_ready}, 32'd1);
      tick();
      chk("t3_a_valid_kept", {31'd0, a_valid}, 32'd1);
      chk("t3_a_data_new", {16'd0, a_data}, 32'hABCD);
      chk("t4_b_drained", {31'd0, b_valid}, 32'd0);
      in_valid = 1'b0;
      tick();
      chk("t3_a_drained", {31'd0, a_valid}, 32'd0);

      // 300 reserved-select words saturate the drop counter
      in_valid = 1'b1; in_sel = 2'b11; in_data = 16'h5555;
      for (int i = 0; i < 300; i++) begin
         #1 chk($sformatf("t5_in_ready_%0d", i), {31'd0, in_ready}, 32'd1);
         tick();
         if (i == 9)   chk("t5_drop_10", {24'd0, drop_count}, 32'd10);
         if (i == 253) chk("t5_drop_254", {24'd0, drop_count}, 32'd254);
      end
      chk("t5_drop_sat", {24'd0, drop_count}, 32'd255);
      chk("t5_a_valid", {31'd0, a_valid}, 32'd0);
      chk("t5_b_valid", {31'd0, b_valid}, 32'd0);
      chk("t5_c_valid", {31'd0, c_valid}, 32'd0);

      // reset overrides held data and a pending load
      a_ready = 1'b0; b_ready = 1'b0;
      in_sel = 2'b00; in_data = 16'h1111;
      tick();
      in_sel = 2'b01; in_data = 16'h2222;
      tick();
      chk("t6_a_full", {31'd0, a_valid}, 32'd1);
      chk("t6_b_full", {31'd0, b_valid}, 32'd1);
      in_sel = 2'b10; in_data = 16'h3333;
      rst = 1'b1;
      tick();
      chk("t6_a_valid", {31'd0, a_valid}, 32'd0);
      chk("t6_b_valid", {31'd0, b_valid}, 32'd0);
      chk("t6_c_valid", {31'd0, c_valid}, 32'd0);
      chk("t6_a_data", {16'd0, a_data}, 32'h0000);
      chk("t6_b_data", {16'd0, b_data}, 32'h0000);
      chk("t6_c_data", {16'd0, c_data}, 32'h0000);
      chk("t6_drop", {24'd0, drop_count}, 32'd0);
      rst = 1'b0; in_valid = 1'b0;
      tick();
      chk("t6_c_no_load", {31'd0, c_valid}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/demux1to3_buf.md
Name: demux1to3_buf

Overview:
- Inverse of the datapath's 3-to-1 result selector: routes one 16-bit word stream to one of three destinations, chosen by a 2-bit select.
- Each destination has a one-entry holding register with a valid/ready handshake, so a stalled consumer blocks only its own channel.
- Select code 11 is reserved. A word sent with it is accepted, discarded and counted.
- Sits between the ALU/memory result source and the register-file, memory-write and PC-update consumers in the multicycle core.

Parameters:
- WIDTH, 16, data word width.
- CNT_W, 8, width of the saturating drop counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  WIDTH  word to route.
- in_sel  in  2  destination: 00=A, 01=B, 10=C, 11=drop.
- in_valid  in  1  in_data/in_sel are valid this cycle.
- in_ready  out  1  block accepts the word this cycle (combinational).
- a_data  out  WIDTH  channel A held word.
- a_valid  out  1  channel A holds a word.
- a_ready  in  1  channel A consumer takes the word.
- b_data, b_valid, b_ready: as channel A, for channel B.
- c_data, c_valid, c_ready: as channel A, for channel C.
- drop_count  out  CNT_W  number of words accepted with in_sel=11, saturating.

Behaviour:
- Reset (rst=1 at a rising edge): a/b/c_valid=0, a/b/c_data=0, drop_count=0. Reset overrides any handshake in the same cycle; words held mid-operation are lost.
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer on channel X occurs when X_valid && X_ready.
- in_ready is combinational with no dependence on in_valid:
  - sel 00/01/10: in_ready = !X_valid || X_ready, for the selected channel X.
  - sel 11: in_ready = 1.
- Latency: a word accepted at edge N is visible on X_data with X_valid=1 after edge N, i.e. one cycle.
- Per-channel holding register, evaluated each edge:
  - load (input transfer targeting X) and no drain: X_data<=in_data, X_valid<=1.
  - load and drain in the same cycle: X_data<=in_data, X_valid stays 1. This gives full throughput of 1 word/cycle per channel.
  - drain only: X_valid<=0. X_data holds its last value.
  - neither: hold.
- Channels are independent. Non-selected channels keep draining while another channel is loaded or stalled.
- Ordering: words to the same channel leave in acceptance order. No ordering guarantee across channels.
- Outputs are stable while stalled: X_data must not change while X_valid=1 and X_ready=0.
- Drop path: an input transfer with in_sel=11 increments drop_count. At 2^CNT_W-1 the count stays there (no wrap). No channel state changes.
- in_valid=0: no load and no count. in_sel and in_data are don't-care.
- Not required:
  - Behaviour when in_sel changes while in_valid=1 and in_ready=0 is not required to be stable; the sender holds in_sel.
  - X_ready while X_valid=0 is ignored.
- No combinational path from in_valid or in_data to any output other than none; X_* and drop_count are registered.

Decomposition:
- Shared package holds:
  - select encodings SEL_A=2'b00, SEL_B=2'b01, SEL_C=2'b10, SEL_DROP=2'b11;
  - default WIDTH=16.
- One sub-module, demux_slot: a one-entry holding register.
  - Inputs: clk, rst, load, load_data, out_ready.
  - Outputs: out_valid, out_data, and can_accept = !out_valid || out_ready.
  - Instantiated three times.
- Top level holds the select decode, the in_ready mux and the drop counter.

Test Plan:
- Reset then idle, all ready=1. Expect every valid=0, every data=0000, drop_count=0, in_ready=1 for every in_sel.
- Send 1234/sel 00, then 0F7A/sel 01, then 7011/sel 10, one per cycle, all ready=1. Expect a_data=1234, b_data=0F7A, c_data=7011, each valid for exactly one cycle, one cycle after its own acceptance.
- Hold a_ready=0 and send 1234/sel 00, then ABCD/sel 00. Expect:
  - in_ready=0 on the second word while a_data stays 1234;
  - after raising a_ready, 1234 drains, ABCD loads the same edge, and a_valid stays 1.
- With a_ready=0 and A full, send 0F7A/sel 01. Expect it accepted immediately and b_data=0F7A next cycle, with A unaffected.
- Send 300 consecutive words with sel 11. Expect in_ready=1 throughout, no channel valid, and drop_count ending at 255 (saturated).
- Assert rst while A and B hold data and in_valid=1/sel 10. Expect all valids=0, all data=0000, drop_count=0 next cycle, and no load of channel C.
